// File: rtl/row_result_drain.sv
// Drains one systolic row's result bus: waits a fixed latency after start,
// snapshots all S accumulators, then streams them out PE0 first.
module row_result_drain #(
   parameter int N   = 8,
   parameter int M   = 18,
   parameter int S   = 8,
   parameter int LAT = 3 * S + N - 1,
   parameter int CW  = 8,
   parameter int IW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [S*M-1:0]  Data,
   output logic [M-1:0]    out_data,
   output logic [IW-1:0]   out_idx,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic            start_err,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [S*M-1:0]   shadow_q, shadow_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [M-1:0]     word_sel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Handshake: a word transfers on a cycle where out_valid && out_ready; while
   // out_valid is high and out_ready low, data/idx/last hold and valid stays up.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = CW'(LAT - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            err_d = start;
            if (cnt_q == '0) begin
               shadow_d = Data;
               idx_d    = '0;
               state_d  = S_STREAM;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_STREAM: begin
            // A start on the final transfer cycle still counts as busy.
            err_d = start;
            if (out_ready) begin
               if (idx_q == IW'(S - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // PE0 sits in the most-significant slice of the shadow register.
   always_comb begin
      word_sel = '0;
      for (int i = 0; i < S; i++) begin
         if (idx_q == IW'(i)) word_sel = shadow_q[(S-1-i)*M +: M];
      end
   end

   assign out_data  = word_sel;
   assign out_idx   = idx_q;
   assign out_valid = (state_q == S_STREAM);
   assign out_last  = (state_q == S_STREAM) && (idx_q == IW'(S - 1));
   assign busy      = (state_q == S_WAIT) || (state_q == S_STREAM);
   assign done      = done_q;
   assign start_err = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_row_result_drain.sv
// Directed bench for row_result_drain: latency, streaming order, stalls,
// capture isolation, busy starts, back-to-back drains and mid-stream reset.
module tb_row_result_drain;

   localparam int N   = 8;
   localparam int M   = 18;
   localparam int S   = 8;
   localparam int LAT = 31;
   localparam int CW  = 8;
   localparam int IW  = 3;

   logic            clk;
   logic            rst;
   logic            start;
   logic [S*M-1:0]  Data;
   logic [M-1:0]    out_data;
   logic [IW-1:0]   out_idx;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            start_err;
   logic [1:0]      dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   row_result_drain #(.N(N), .M(M), .S(S), .LAT(LAT), .CW(CW), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .Data      (Data),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .start_err (start_err),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [S*M-1:0] pack(input logic [M-1:0] base);
      logic [S*M-1:0] d;
      d = '0;
      for (int i = 0; i < S; i++) d[(S-1-i)*M +: M] = M'(int'(base) + i);
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start, then waits for out_valid; lat counts edges after the start edge.
   task automatic launch_and_wait(input int err_at, output int lat, output int errs);
      int n;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      errs = 0;
      if (start_err) errs++;
      while (!out_valid && n < 200) begin
         start = (n == err_at);
         step();
         n++;
         if (start_err) errs++;
      end
      start = 1'b0;
      lat = n;
   endtask

   // Consumes one stream; leaves the bench at the sample point where done should be high.
   task automatic run_stream(input logic [M-1:0] base, input int stall2, input int stall7,
                             input bit clobber, input int start_idx, output int errs);
      logic [M+IW+2:0] got, exp;
      int stalls;
      errs = 0;
      for (int i = 0; i < S; i++) begin
         stalls = (i == 2) ? stall2 : ((i == 7) ? stall7 : 0);
         for (int s = 0; s <= stalls; s++) begin
            out_ready = (s == stalls);
            start = (i == start_idx) && (s == stalls);
            if (clobber && i == 0 && s == 0) Data = '1;
            got = {out_valid, out_data, out_idx, out_last, busy};
            exp = {1'b1, M'(int'(base) + i), IW'(i), 1'(i == S - 1), 1'b1};
            n_cmp++;
            if (got !== exp) begin
               n_bad++;
               $display("FAIL word%0d_cyc%0d {valid,data,idx,last,busy}: got %h expected %h",
                        i, s, got, exp);
            end
            step();
            if (start_err) errs++;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if ({done, out_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL stream_end {done,valid,busy}: got %b expected 100", {done, out_valid, busy});
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({out_data, out_idx, out_valid, out_last, busy, done, start_err, dbg_state} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {out_data, out_idx, out_valid, out_last, busy, done, start_err, dbg_state});
      end
   endtask

   task automatic test_basic();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      n_cmp++;
      if (lat !== LAT) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
      end
      run_stream(18'h100, 0, 0, 1'b0, -1, errs);
      step();
      n_cmp++;
      if ({done, errs[0]} !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_done_fall_err: got %b expected 00", {done, errs[0]});
      end
   endtask

   task automatic test_backpressure();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      n_cmp++;
      if (lat !== LAT) begin
         n_bad++;
         $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
      end
      run_stream(18'h100, 3, 1, 1'b0, -1, errs);
      step();
   endtask

   task automatic test_capture_isolation();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      run_stream(18'h100, 0, 0, 1'b1, -1, errs);
      n_cmp++;
      if (Data !== {(S*M){1'b1}}) begin
         n_bad++;
         $display("FAIL iso_data_driven: got %h expected all ones", Data);
      end
      step();
   endtask

   task automatic test_busy_start();
      int lat, errs_w, errs_s;
      Data = pack(18'h100);
      launch_and_wait(5, lat, errs_w);
      n_cmp++;
      if (lat !== LAT || errs_w !== 1) begin
         n_bad++;
         $display("FAIL busy_wait lat/errs: got %0d/%0d expected %0d/1", lat, errs_w, LAT);
      end
      run_stream(18'h100, 0, 0, 1'b0, 4, errs_s);
      n_cmp++;
      if (errs_s !== 1) begin
         n_bad++;
         $display("FAIL busy_stream_errs: got %0d expected 1", errs_s);
      end
      step();
   endtask

   task automatic test_last_start();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      run_stream(18'h100, 0, 0, 1'b0, 7, errs);
      n_cmp++;
      if (errs !== 1 || dbg_state !== 2'd0) begin
         n_bad++;
         $display("FAIL last_start errs/state: got %0d/%0d expected 1/0", errs, dbg_state);
      end
      step();
      n_cmp++;
      if ({busy, start_err} !== 2'b00) begin
         n_bad++;
         $display("FAIL last_start_ignored {busy,err}: got %b expected 00", {busy, start_err});
      end
   endtask

   task automatic test_back_to_back();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      run_stream(18'h100, 0, 0, 1'b0, -1, errs);
      Data = pack(18'h200);
      launch_and_wait(-1, lat, errs);
      n_cmp++;
      if (lat !== LAT || errs !== 0) begin
         n_bad++;
         $display("FAIL b2b lat/errs: got %0d/%0d expected %0d/0", lat, errs, LAT);
      end
      run_stream(18'h200, 0, 0, 1'b0, -1, errs);
      n_cmp++;
      if (errs !== 0) begin
         n_bad++;
         $display("FAIL b2b_stream_errs: got %0d expected 0", errs);
      end
      step();
   endtask

   task automatic test_reset_mid_stream();
      int lat, errs;
      Data = pack(18'h100);
      launch_and_wait(-1, lat, errs);
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 3'd3, 18'h103}) begin
         n_bad++;
         $display("FAIL rst_pre_idx3: got %h expected %h", {out_valid, out_idx, out_data},
                  {1'b1, 3'd3, 18'h103});
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, busy, done, out_idx, out_data, out_last, start_err} !== '0) begin
         n_bad++;
         $display("FAIL rst_async_outputs: got %h expected 0",
                  {out_valid, busy, done, out_idx, out_data, out_last, start_err});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      n_cmp++;
      if ({out_valid, busy, dbg_state} !== 4'b0) begin
         n_bad++;
         $display("FAIL rst_no_resume: got %b expected 0000", {out_valid, busy, dbg_state});
      end
      launch_and_wait(-1, lat, errs);
      n_cmp++;
      if (lat !== LAT) begin
         n_bad++;
         $display("FAIL rst_restart_latency: got %0d expected %0d", lat, LAT);
      end
      run_stream(18'h100, 0, 0, 1'b0, -1, errs);
      step();
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      Data = pack(18'h100);
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      step();
      test_basic();
      test_backpressure();
      test_capture_isolation();
      test_busy_start();
      test_last_start();
      test_back_to_back();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/row_result_drain.md
Name: row_result_drain

Overview:
- Reader side of the systolic row's result bus. The row presents S accumulators of M bits each, concatenated on one S*M-bit bus, with PE0 in the most-significant slice.
- On a start pulse, the block waits a programmable fill/compute latency, then snapshots the whole bus into a shadow register.
- It then streams the results out one M-bit word per cycle over a valid/ready handshake, PE0 first.
- It sits between each systolic row and the result memory/output formatter.

Parameters:
- N, 8, operand width of the array (used only to derive the default latency).
- M, 18, accumulator/result word width.
- S, 8, number of PEs per row = number of result words per drain.
- LAT, 3*S+N-1 (=31), cycles from start to a valid result bus; must be >= 1.
- CW, 8, width of the latency counter; must satisfy 2^CW > LAT.
- IW, 3, width of the word index; must satisfy 2^IW >= S.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to drain one result set.
- Data, input, S*M, result bus from the row; PE i occupies [S*M-1-i*M : S*M-M-i*M].
- out_data, output, M, current result word.
- out_idx, output, IW, PE index of out_data, from 0 to S-1.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts the word.
- out_last, output, 1, high with out_valid on word S-1.
- busy, output, 1, high in WAIT or STREAM.
- done, output, 1, one-cycle pulse after the last word is accepted.
- start_err, output, 1, one-cycle pulse when start arrives while busy.

Behaviour:
- Reset: asynchronous, active-low, and it may arrive at any time, including mid-stream.
  - On assertion: state = IDLE; counter, index and shadow register are 0.
  - Outputs during reset: out_data = 0, out_idx = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, start_err = 0.
  - After reset a new start must be issued; no partial stream resumes.
- States:
  - IDLE: on start, load counter = LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter equals 0, capture Data into the shadow register, clear the index and go to STREAM.
  - STREAM: out_valid = 1 and out_data = shadow word[idx], driven from registers.
    - On out_valid & out_ready: if idx == S-1, go to IDLE and pulse done in the following cycle. Otherwise idx increments.
- Latency:
  - start high at edge t: Data is sampled at edge t+LAT, and out_valid rises after edge t+LAT.
  - With out_ready held high, S words are delivered in S consecutive cycles, and done is high in the cycle after the last transfer.
- Handshake:
  - out_data, out_idx and out_last stay stable while out_valid & !out_ready, for any number of stall cycles.
  - out_valid never drops without a transfer.
  - out_ready sampled while out_valid = 0 has no effect.
- Data changes after the capture edge do not affect the words already captured and being streamed.
- start while busy (WAIT or STREAM): ignored, the state is unchanged, and start_err pulses in the next cycle.
- start in the same cycle that the last word transfers: treated as busy, so start_err pulses and the start is ignored.
- start in the cycle done is high: accepted, because the block is already IDLE.
- out_last = out_valid & (idx == S-1).
- busy is 1 in WAIT and STREAM.
- No arithmetic is performed on the data; words pass through bit-exact.

Test Plan:
- Basic drain:
  - Stimulus: reset, then start; Data word i = 18'h100+i; out_ready = 1.
  - Required: out_valid rises 31 cycles after start. Words 0x100..0x107 appear with idx 0..7 on consecutive cycles, out_last on idx 7, and done one cycle later.
- Backpressure:
  - Stimulus: as basic drain, with out_ready low for 3 cycles at idx 2 and again for 1 cycle at idx 7.
  - Required: 0x102 is held for 4 cycles and 0x107/out_last for 2 cycles. No word is lost or duplicated, and done comes one cycle after the idx 7 transfer.
- Capture isolation:
  - Stimulus: change every Data word to 18'h3FFFF in the cycle after capture.
  - Required: the stream is still 0x100..0x107.
- Busy start:
  - Stimulus: start at WAIT cycle 5, and again during STREAM idx 4.
  - Required: start_err pulses once for each start, and the timing and data match the basic drain.
- Back-to-back:
  - Stimulus: second start in the done cycle, with Data word i = 18'h200+i.
  - Required: the second stream 0x200..0x207 begins 31 cycles after that start, and start_err stays 0.
- Reset mid-stream:
  - Stimulus: pull rst low asynchronously (between clock edges) at idx 3.
  - Required: out_valid, busy, done and out_idx go to 0 immediately. After release, a new start yields a full 8-word stream from idx 0.
